// File: rtl/rx_cmd_parser.sv
// rx_cmd_parser
//   Parses received Ethernet frames carrying a small register command and
//   turns accepted commands into single-cycle register read/write strobes.
//   Frame layout: DST(6) SRC(6) TYPE(2) then payload
//   MAGIC, CMD (FF = write, 00 = read), ADDR, DATA, padding.
//   A command only takes effect when the frame ends with rx_good_frame while
//   the parser sits in PAD. Every other end of a parsed frame counts a drop.
//
// Parameters
//   LOCAL_MAC  station address compared with the destination (filter build)
//   CMD_MAGIC  required first payload byte
//
// Ports
//   rx_clk         clock, everything on the rising edge
//   reset          synchronous active-high reset
//   rx_data        received byte
//   rx_data_valid  byte qualifier, high for the whole frame
//   rx_good_frame  end-of-frame pulse, FCS ok
//   rx_bad_frame   end-of-frame pulse, frame failed
//   reg_wr/reg_rd  one-cycle register strobes, cycle after the good pulse
//   reg_addr       command address, held until the next strobe
//   reg_wdata      write data, held until the next write strobe
//   frame_cnt      accepted command count (wrapping)
//   drop_cnt       rejected frame count (wrapping)
//
// Build option
//   RX_CMD_MAC_FILTER_EN  when defined, frames whose destination is neither
//                         LOCAL_MAC nor broadcast are dropped after the 6th
//                         destination byte. Undefined: destination ignored.
module rx_cmd_parser #(
    parameter logic [47:0] LOCAL_MAC = 48'h0EDA02030405,
    parameter logic [7:0]  CMD_MAGIC = 8'hFF
) (
    input  logic        rx_clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    input  logic        rx_good_frame,
    input  logic        rx_bad_frame,
    output logic        reg_wr,
    output logic        reg_rd,
    output logic [7:0]  reg_addr,
    output logic [7:0]  reg_wdata,
    output logic [15:0] frame_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [3:0] {
        IDLE, DST, SRC, TYPE, MAGIC, CMD, ADDR, DATA, PAD, DROP
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  byte_cnt_reg, byte_cnt_next;
    logic        valid_d_reg;
    logic        skip_reg;         // set by reset: ignore bytes until valid drops
    logic        is_wr_reg, is_wr_next;
    logic [7:0]  addr_sh_reg, addr_sh_next;
    logic [7:0]  data_sh_reg, data_sh_next;
    logic        reg_wr_reg, reg_rd_reg;
    logic [7:0]  reg_addr_reg, reg_wdata_reg;
    logic [15:0] frame_cnt_reg, frame_cnt_next;
    logic [15:0] drop_cnt_reg, drop_cnt_next;

    logic rise, end_any, end_good, end_seen, commit, drop_inc;

`ifdef RX_CMD_MAC_FILTER_EN
    // Only the first five destination bytes are stored; the sixth is
    // compared straight off rx_data.
    logic [39:0] dst_reg, dst_next;
    logic [47:0] dst_full;
    logic        dst_ok;
    assign dst_full = {dst_reg, rx_data};
    assign dst_ok   = (dst_full == LOCAL_MAC) || (dst_full == 48'hFFFFFFFFFFFF);
`else
    // Keeps the parameter referenced when no address comparator is built.
    localparam logic [47:0] unused_local_mac = LOCAL_MAC;
`endif

    assign rise     = rx_data_valid && !valid_d_reg && !skip_reg;
    assign end_any  = rx_good_frame || rx_bad_frame;
    assign end_good = rx_good_frame && !rx_bad_frame;
    assign end_seen = (state_reg != IDLE) && end_any;

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        is_wr_next    = is_wr_reg;
        addr_sh_next  = addr_sh_reg;
        data_sh_next  = data_sh_reg;
        commit        = 1'b0;
        drop_inc      = 1'b0;
`ifdef RX_CMD_MAC_FILTER_EN
        dst_next      = dst_reg;
`endif
        if (end_seen) begin
            if (end_good && state_reg == PAD) commit = 1'b1;
            else                              drop_inc = 1'b1;
            state_next = IDLE;
        end else if (rise && state_reg != IDLE) begin
            // New frame started before the old one ended.
            drop_inc = 1'b1;
        end

        if (rise) begin
            // The rising-edge byte is destination byte 0.
            state_next    = DST;
            byte_cnt_next = 3'd1;
`ifdef RX_CMD_MAC_FILTER_EN
            dst_next      = {dst_reg[31:0], rx_data};
`endif
        end else if (rx_data_valid && !end_seen) begin
            case (state_reg)
                DST: begin
`ifdef RX_CMD_MAC_FILTER_EN
                    dst_next = {dst_reg[31:0], rx_data};
`endif
                    if (byte_cnt_reg == 3'd5) begin
                        byte_cnt_next = 3'd0;
`ifdef RX_CMD_MAC_FILTER_EN
                        state_next    = dst_ok ? SRC : DROP;
`else
                        state_next    = SRC;
`endif
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 3'd1;
                    end
                end
                SRC: begin
                    if (byte_cnt_reg == 3'd5) begin
                        byte_cnt_next = 3'd0;
                        state_next    = TYPE;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 3'd1;
                    end
                end
                TYPE: begin
                    if (byte_cnt_reg == 3'd1) begin
                        byte_cnt_next = 3'd0;
                        state_next    = MAGIC;
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 3'd1;
                    end
                end
                MAGIC: state_next = (rx_data == CMD_MAGIC) ? CMD : DROP;
                CMD: begin
                    if (rx_data == 8'hFF) begin
                        is_wr_next = 1'b1;
                        state_next = ADDR;
                    end else if (rx_data == 8'h00) begin
                        is_wr_next = 1'b0;
                        state_next = ADDR;
                    end else begin
                        state_next = DROP;
                    end
                end
                ADDR: begin
                    addr_sh_next = rx_data;
                    state_next   = DATA;
                end
                DATA: begin
                    data_sh_next = rx_data;
                    state_next   = PAD;
                end
                default: ;  // IDLE (no edge), PAD and DROP absorb bytes
            endcase
        end

        frame_cnt_next = frame_cnt_reg + {15'd0, commit};
        drop_cnt_next  = drop_cnt_reg + {15'd0, drop_inc};
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            byte_cnt_reg  <= 3'd0;
            valid_d_reg   <= 1'b0;
            skip_reg      <= 1'b1;
            is_wr_reg     <= 1'b0;
            addr_sh_reg   <= 8'h00;
            data_sh_reg   <= 8'h00;
            reg_wr_reg    <= 1'b0;
            reg_rd_reg    <= 1'b0;
            reg_addr_reg  <= 8'h00;
            reg_wdata_reg <= 8'h00;
            frame_cnt_reg <= 16'h0000;
            drop_cnt_reg  <= 16'h0000;
`ifdef RX_CMD_MAC_FILTER_EN
            dst_reg       <= 40'd0;
`endif
        end else begin
            state_reg     <= state_next;
            byte_cnt_reg  <= byte_cnt_next;
            valid_d_reg   <= rx_data_valid;
            if (!rx_data_valid) skip_reg <= 1'b0;
            is_wr_reg     <= is_wr_next;
            addr_sh_reg   <= addr_sh_next;
            data_sh_reg   <= data_sh_next;
            reg_wr_reg    <= commit && is_wr_reg;
            reg_rd_reg    <= commit && !is_wr_reg;
            if (commit) reg_addr_reg <= addr_sh_reg;
            if (commit && is_wr_reg) reg_wdata_reg <= data_sh_reg;
            frame_cnt_reg <= frame_cnt_next;
            drop_cnt_reg  <= drop_cnt_next;
`ifdef RX_CMD_MAC_FILTER_EN
            dst_reg       <= dst_next;
`endif
        end
    end

    assign reg_wr    = reg_wr_reg;
    assign reg_rd    = reg_rd_reg;
    assign reg_addr  = reg_addr_reg;
    assign reg_wdata = reg_wdata_reg;
    assign frame_cnt = frame_cnt_reg;
    assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_rx_cmd_parser.sv
// Testbench for rx_cmd_parser: table of frames with expected outcome,
// scoreboard of expected strobes checked by a monitor, plus hand-written
// sequences for reset mid-frame, restart on a new edge, idle pulses and
// frame counter wrap.
module tb_rx_cmd_parser;

    localparam logic [47:0] LOCAL_MAC = 48'h0EDA02030405;

    logic        rx_clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_data_valid = 1'b0;
    logic        rx_good_frame = 1'b0;
    logic        rx_bad_frame = 1'b0;
    logic        reg_wr, reg_rd;
    logic [7:0]  reg_addr, reg_wdata;
    logic [15:0] frame_cnt, drop_cnt;

    always #5 rx_clk = ~rx_clk;

    rx_cmd_parser #(.LOCAL_MAC(LOCAL_MAC), .CMD_MAGIC(8'hFF)) dut (
        .rx_clk(rx_clk), .reset(reset), .rx_data(rx_data),
        .rx_data_valid(rx_data_valid), .rx_good_frame(rx_good_frame),
        .rx_bad_frame(rx_bad_frame), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
    );

    // exp: 0 = rejected, 1 = write strobe, 2 = read strobe
    typedef struct {
        logic [47:0] dst;
        logic [7:0]  magic;
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  data;
        int          npay;
        logic        good;
        logic        bad;
        int          exp;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [15:0] fcnt;
    } sb_t;

    sb_t         sb_q[$];
    logic [7:0]  frame_q[$];
    vec_t        vecs[11];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_frame = 16'h0000;
    logic [15:0] m_drop = 16'h0000;
    logic [7:0]  m_addr = 8'h00;
    logic [7:0]  m_wdata = 8'h00;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected commit.
    initial begin
        forever begin
            @(negedge rx_clk);
            if (!reset && (reg_wr || reg_rd)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe actual wr=%0b rd=%0b required none", reg_wr, reg_rd);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("strobe_wr", reg_wr, e.wr);
                    check("strobe_rd", reg_rd, e.rd);
                    check("strobe_addr", reg_addr, e.addr);
                    check("strobe_wdata", reg_wdata, e.wdata);
                    check("strobe_frame_cnt", frame_cnt, e.fcnt);
                    $display("strobe wr=%0b rd=%0b addr=%02h wdata=%02h frame_cnt=%0d",
                             reg_wr, reg_rd, reg_addr, reg_wdata, frame_cnt);
                end
            end
        end
    end

    task automatic build_frame(input vec_t v);
        logic [7:0] pl [4];
        pl[0] = v.magic; pl[1] = v.cmd; pl[2] = v.addr; pl[3] = v.data;
        frame_q.delete();
        for (int i = 0; i < 6; i++) frame_q.push_back(v.dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) frame_q.push_back(8'h10 + 8'(i));
        frame_q.push_back(8'h88);
        frame_q.push_back(8'hB5);
        for (int i = 0; i < v.npay; i++) frame_q.push_back(i < 4 ? pl[i] : 8'h5A);
    endtask

    task automatic drive_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            @(negedge rx_clk);
            rx_data_valid = 1'b1;
            rx_data = frame_q[i];
        end
    endtask

    task automatic end_frame(input logic g, input logic b);
        @(negedge rx_clk);
        rx_data_valid = 1'b0;
        rx_data = 8'h00;
        rx_good_frame = g;
        rx_bad_frame = b;
        @(negedge rx_clk);
        rx_good_frame = 1'b0;
        rx_bad_frame = 1'b0;
    endtask

    task automatic expect_outcome(input int exp, input logic [7:0] addr, input logic [7:0] data);
        sb_t e;
        if (exp == 0) begin
            m_drop = m_drop + 16'd1;
        end else begin
            m_frame = m_frame + 16'd1;
            m_addr = addr;
            if (exp == 1) m_wdata = data;
            e.wr = (exp == 1);
            e.rd = (exp == 2);
            e.addr = m_addr;
            e.wdata = m_wdata;
            e.fcnt = m_frame;
            sb_q.push_back(e);
        end
    endtask

    task automatic settle_check(input string tag);
        repeat (2) @(negedge rx_clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobe %s actual=none required=%0d pending", tag, sb_q.size());
            sb_q.delete();
        end
        check({tag, "_frame_cnt"}, frame_cnt, m_frame);
        check({tag, "_drop_cnt"}, drop_cnt, m_drop);
        $display("%s: frame_cnt=%0d drop_cnt=%0d", tag, frame_cnt, drop_cnt);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        build_frame(v);
        drive_bytes(0, frame_q.size());
        expect_outcome(v.exp, v.addr, v.data);
        end_frame(v.good, v.bad);
        settle_check(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reg_wr"}, reg_wr, 1'b0);
        check({tag, "_reg_rd"}, reg_rd, 1'b0);
        check({tag, "_reg_addr"}, reg_addr, 8'h00);
        check({tag, "_reg_wdata"}, reg_wdata, 8'h00);
        check({tag, "_frame_cnt"}, frame_cnt, 16'h0000);
        check({tag, "_drop_cnt"}, drop_cnt, 16'h0000);
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{LOCAL_MAC,        8'hFF, 8'hFF, 8'hAA, 8'hDD, 6,  1'b1, 1'b0, 1};
        vecs[1]  = '{LOCAL_MAC,        8'hFF, 8'h00, 8'h5C, 8'h11, 6,  1'b1, 1'b0, 2};
        vecs[2]  = '{LOCAL_MAC,        8'hFF, 8'hFF, 8'h12, 8'h34, 6,  1'b1, 1'b1, 0};
        vecs[3]  = '{LOCAL_MAC,        8'hFF, 8'hFF, 8'h12, 8'h34, 6,  1'b0, 1'b1, 0};
        vecs[4]  = '{LOCAL_MAC,        8'h7E, 8'hFF, 8'h12, 8'h34, 6,  1'b1, 1'b0, 0};
        vecs[5]  = '{LOCAL_MAC,        8'hFF, 8'h55, 8'h12, 8'h34, 6,  1'b1, 1'b0, 0};
        vecs[6]  = '{48'hFFFFFFFFFFFF, 8'hFF, 8'hFF, 8'h01, 8'h02, 6,  1'b1, 1'b0, 1};
`ifdef RX_CMD_MAC_FILTER_EN
        vecs[7]  = '{48'h0E0203040506, 8'hFF, 8'hFF, 8'h03, 8'h04, 6,  1'b1, 1'b0, 0};
`else
        vecs[7]  = '{48'h0E0203040506, 8'hFF, 8'hFF, 8'h03, 8'h04, 6,  1'b1, 1'b0, 1};
`endif
        vecs[8]  = '{LOCAL_MAC,        8'hFF, 8'hFF, 8'h77, 8'h88, 3,  1'b1, 1'b0, 0};
        vecs[9]  = '{LOCAL_MAC,        8'hFF, 8'hFF, 8'h99, 8'h66, 4,  1'b1, 1'b0, 1};
        vecs[10] = '{LOCAL_MAC,        8'hFF, 8'h00, 8'h42, 8'h00, 20, 1'b1, 1'b0, 2};

        repeat (3) @(negedge rx_clk);
        reset = 1'b0;
        @(negedge rx_clk);
        check_all_zero("reset");

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Pulses while idle are ignored.
        end_frame(1'b1, 1'b0);
        end_frame(1'b0, 1'b1);
        settle_check("idle_pulses");

        // Truncated frame followed by a new rising edge: one drop, then the
        // new frame parses from its first byte.
        v = '{LOCAL_MAC, 8'hFF, 8'hFF, 8'h21, 8'h22, 4, 1'b1, 1'b0, 1};
        build_frame(v);
        drive_bytes(0, 10);
        @(negedge rx_clk);
        rx_data_valid = 1'b0;
        @(negedge rx_clk);
        m_drop = m_drop + 16'd1;
        run_vec(v, "restart");

        // Reset while the address byte is on the bus; the rest of the frame
        // and its good pulse must be ignored.
        v = '{LOCAL_MAC, 8'hFF, 8'hFF, 8'h31, 8'h32, 4, 1'b1, 1'b0, 1};
        build_frame(v);
        drive_bytes(0, 16);
        @(negedge rx_clk);
        reset = 1'b1;
        rx_data_valid = 1'b1;
        rx_data = frame_q[16];
        @(negedge rx_clk);
        reset = 1'b0;
        rx_data = frame_q[17];
        check_all_zero("mid_reset");
        m_frame = 16'h0000; m_drop = 16'h0000; m_addr = 8'h00; m_wdata = 8'h00;
        drive_bytes(18, frame_q.size());
        end_frame(1'b1, 1'b0);
        settle_check("after_reset_tail");
        run_vec(v, "after_reset_frame");

        // Frame counter wrap.
        @(negedge rx_clk);
        force dut.frame_cnt_reg = 16'hFFFF;
        repeat (2) @(negedge rx_clk);
        release dut.frame_cnt_reg;
        m_frame = 16'hFFFF;
        @(negedge rx_clk);
        check("preload_frame_cnt", frame_cnt, 16'hFFFF);
        v = '{LOCAL_MAC, 8'hFF, 8'hFF, 8'h4B, 8'hC3, 5, 1'b1, 1'b0, 1};
        run_vec(v, "wrap");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_cmd_parser.md
RX_CMD_PARSER -- requirements
Module: rx_cmd_parser

Interface
REQ-001 SHALL have parameter LOCAL_MAC, default 48'h0EDA02030405: station address matched against the destination MAC.
REQ-002 SHALL have parameter CMD_MAGIC, default 8'hFF: required first payload byte.
REQ-003 rx_clk  input  1  sole clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received client byte from the MAC.
REQ-006 rx_data_valid  input  1  rx_data qualifier, high for the whole frame from the first destination byte.
REQ-007 rx_good_frame  input  1  single-cycle pulse, no earlier than the cycle after the last valid byte; frame passed FCS.
REQ-008 rx_bad_frame  input  1  single-cycle pulse with the same timing; frame failed.
REQ-009 reg_wr  output  1  one-cycle register write strobe.
REQ-010 reg_rd  output  1  one-cycle register read strobe.
REQ-011 reg_addr  output  8  command address, stable from the strobe until the next strobe.
REQ-012 reg_wdata  output  8  write data, stable from the strobe until the next strobe.
REQ-013 frame_cnt  output  16  count of accepted commands, wraps at 16'hFFFF to 0.
REQ-014 drop_cnt  output  16  count of rejected frames, wraps at 16'hFFFF to 0.

Function
REQ-015 SHALL take the frame start as rx_data_valid high while it was low the previous cycle; bytes with valid high in IDLE without a rising edge SHALL be ignored.
REQ-016 States SHALL be IDLE, DST (6 bytes), SRC (6), TYPE (2), MAGIC, CMD, ADDR, DATA, PAD, DROP, each advancing on valid bytes only.
REQ-017 Byte order: DST bytes MSB first; TYPE discarded; payload byte 0 = magic, 1 = command, 2 = address, 3 = data; remaining bytes discarded in PAD.
REQ-018 Command 8'hFF SHALL mean write and 8'h00 read; any other command value, or a magic byte not equal to CMD_MAGIC, SHALL move to DROP.
REQ-019 Address and data SHALL be captured into shadow registers; reg_addr/reg_wdata SHALL update only on commit.
REQ-020 Commit: rx_good_frame sampled in PAD (data byte captured) SHALL assert reg_wr (write) or reg_rd (read) for exactly one cycle, on the cycle after the pulse, and increment frame_cnt in the same cycle.
REQ-021 A read SHALL leave reg_wdata unchanged.
REQ-022 Reject: rx_bad_frame in any state, or rx_good_frame before PAD, or any end pulse in DROP, SHALL increment drop_cnt once, issue no strobe, and return to IDLE.
REQ-023 rx_good_frame and rx_bad_frame together SHALL be treated as bad.
REQ-024 rx_data_valid falling with no end pulse SHALL hold the state until an end pulse or a new rising edge; a rising edge outside IDLE SHALL count one drop and restart the parse at DST.
REQ-025 End pulses sampled in IDLE SHALL be ignored (no count).
REQ-026 reg_wr and reg_rd SHALL never be high together; at most one strobe per frame.

Reset
REQ-027 On reset: state IDLE; reg_wr, reg_rd = 0; reg_addr, reg_wdata = 8'h00; frame_cnt, drop_cnt = 16'h0000; shadow registers and the valid-edge history = 0.
REQ-028 Reset mid-frame SHALL discard the frame without counting it; the remaining bytes SHALL be ignored until valid goes low and rises again.

Configuration
REQ-029 Macro RX_CMD_MAC_FILTER_EN defined: in DST, a destination not equal to LOCAL_MAC and not 48'hFFFFFFFFFFFF SHALL move to DROP after the 6th byte.
REQ-030 Macro RX_CMD_MAC_FILTER_EN undefined: the destination SHALL be ignored and every frame parsed; the LOCAL_MAC comparator SHALL not be synthesised.

Verification
REQ-031 Frame with dst LOCAL_MAC, payload FF FF AA DD, then rx_good_frame -> reg_wr for one cycle the next cycle, reg_addr=AA, reg_wdata=DD, frame_cnt=1.
REQ-032 Same frame with command byte 00 -> reg_rd pulse, reg_addr=AA, reg_wdata unchanged, frame_cnt increments.
REQ-033 Valid write frame ending with rx_bad_frame, or with good and bad together -> no strobe, drop_cnt=1.
REQ-034 Magic byte 7E, or command byte 55 -> no strobe, drop_cnt increments at the end pulse.
REQ-035 Filter on, dst 0E..06 -> drop; broadcast dst -> accepted. Filter off, same mismatched dst -> accepted.
REQ-036 Reset asserted during ADDR -> all outputs zero; the next valid frame commits normally; preload frame_cnt=FFFF, accept a frame -> 0000.
